// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares one ALU datapath between N_REQ requesters. One operation at a time is
// accepted (round-robin), its operands are latched, the ALU is driven for one
// cycle, and after ALU_LATENCY cycles the ALU result is captured and returned
// to the originating requester with a one-cycle valid pulse. All ALU inputs are
// held at zero outside the issue cycle to keep the datapath quiet.
//
// Ports:
//   clk        in   clock
//   async_rst  in   asynchronous active-low reset
//   req        in   [N_REQ]              level request per requester
//   req_fun    in   [N_REQ*FUN_WIDTH]    function code, requester i at i*FUN_WIDTH
//   req_a/b    in   [N_REQ*DATA_WIDTH]   operands, requester i at i*DATA_WIDTH
//   req_ack    out  [N_REQ]              one-hot pulse: request accepted
//   rsp_valid  out  [N_REQ]              one-hot pulse: rsp_data is for requester i
//   rsp_data   out  [DATA_WIDTH]         captured ALU result, held until next capture
//   busy       out                       high whenever not IDLE
//   alu_en     out                       ALU enable (one cycle per operation)
//   alu_fun    out  [FUN_WIDTH]          ALU function
//   alu_a/b    out  [DATA_WIDTH]         ALU operands
//   alu_out    in   [DATA_WIDTH]         ALU registered result
//
// Handshake: a requester raises req with stable fun/a/b; the arbiter samples
// it only while IDLE, answers with a one-cycle req_ack, after which the
// requester drops req. Later, rsp_valid pulses for one cycle with rsp_data.
// A req still high in the IDLE cycle after rsp_valid is a new request.
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int FUN_WIDTH   = 4,
    parameter int N_REQ       = 2,
    parameter int ALU_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          async_rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*FUN_WIDTH-1:0]    req_fun,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]              req_ack,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy,
    output logic                          alu_en,
    output logic [FUN_WIDTH-1:0]          alu_fun,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    input  logic [DATA_WIDTH-1:0]         alu_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        g_q, g_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FUN_WIDTH-1:0]    fun_q, fun_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0]        req_ack_q, req_ack_d;
    logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;

    // Round-robin pick: first set req bit scanning ptr, ptr+1, ... wrapping at N_REQ.
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;

    always_comb begin
        int scan;
        sel_found = 1'b0;
        sel_idx   = '0;
        scan      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = int'(ptr_q) + i;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            if (!sel_found && req[IDX_W'(scan)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(scan);
            end
        end
    end

    // Next-state and datapath latching.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        fun_d       = fun_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_data_d  = rsp_data_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    g_d            = sel_idx;
                    fun_d          = req_fun[sel_idx*FUN_WIDTH +: FUN_WIDTH];
                    a_d            = req_a[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    b_d            = req_b[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    req_ack_d[sel_idx] = 1'b1;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(ALU_LATENCY);
                // Priority moves past the requester just served.
                ptr_d   = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + IDX_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d       = alu_out;
                    rsp_valid_d[g_q] = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            cnt_q       <= '0;
            fun_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            fun_q       <= fun_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_data_q  <= rsp_data_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // ALU drive is gated by the ISSUE state so operands never toggle the
    // datapath outside the single issue cycle.
    always_comb begin
        alu_en  = (state_q == ST_ISSUE);
        alu_fun = alu_en ? fun_q : '0;
        alu_a   = alu_en ? a_q   : '0;
        alu_b   = alu_en ? b_q   : '0;
    end

    assign busy      = (state_q != ST_IDLE);
    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Directed bench for alu_req_arbiter. Two instances: one with ALU_LATENCY=1
// (suffix 1) and one with ALU_LATENCY=4 (suffix 4), each with its own
// registered ALU model (fun 1 -> A-B, otherwise A+B). Inputs change and
// outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_req_arbiter;

    localparam int DW = 16;
    localparam int FW = 4;
    localparam int NR = 2;

    logic clk;
    logic async_rst;

    // Instance with ALU_LATENCY = 1
    logic [NR-1:0]    req1;
    logic [NR*FW-1:0] req_fun1;
    logic [NR*DW-1:0] req_a1, req_b1;
    logic [NR-1:0]    req_ack1, rsp_valid1;
    logic [DW-1:0]    rsp_data1;
    logic             busy1, alu_en1;
    logic [FW-1:0]    alu_fun1;
    logic [DW-1:0]    alu_a1, alu_b1, alu_out1;

    // Instance with ALU_LATENCY = 4
    logic [NR-1:0]    req4;
    logic [NR*FW-1:0] req_fun4;
    logic [NR*DW-1:0] req_a4, req_b4;
    logic [NR-1:0]    req_ack4, rsp_valid4;
    logic [DW-1:0]    rsp_data4;
    logic             busy4, alu_en4;
    logic [FW-1:0]    alu_fun4;
    logic [DW-1:0]    alu_a4, alu_b4, alu_out4;

    int total;
    int bad;

    logic [DW-1:0] exp_q[$];

    alu_req_arbiter #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .N_REQ(NR), .ALU_LATENCY(1)) dut1 (
        .clk(clk), .async_rst(async_rst),
        .req(req1), .req_fun(req_fun1), .req_a(req_a1), .req_b(req_b1),
        .req_ack(req_ack1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .busy(busy1), .alu_en(alu_en1), .alu_fun(alu_fun1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_out(alu_out1)
    );

    alu_req_arbiter #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .N_REQ(NR), .ALU_LATENCY(4)) dut4 (
        .clk(clk), .async_rst(async_rst),
        .req(req4), .req_fun(req_fun4), .req_a(req_a4), .req_b(req_b4),
        .req_ack(req_ack4), .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
        .busy(busy4), .alu_en(alu_en4), .alu_fun(alu_fun4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_out(alu_out4)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [FW-1:0] f, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        return (f == 4'd1) ? a - b : a + b;
    endfunction

    // ALU models
    logic [DW-1:0] p4 [4];

    always @(posedge clk) begin
        alu_out1 <= alu_f(alu_fun1, alu_a1, alu_b1);
        p4[0]    <= alu_f(alu_fun4, alu_a4, alu_b4);
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign alu_out4 = p4[3];

    // Reset pulse spanning two rising edges; returns on a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        async_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        async_rst = 1'b1;
    endtask

    task automatic test_reset();
        async_rst = 1'b0;
        #1;
        total++;
        if ({req_ack1, rsp_valid1, busy1, alu_en1, alu_fun1, alu_a1, alu_b1, rsp_data1} !== '0) begin
            bad++;
            $display("FAIL reset_l1: got ack=%b rv=%b busy=%b en=%b fun=%h a=%h b=%h data=%h required all 0",
                     req_ack1, rsp_valid1, busy1, alu_en1, alu_fun1, alu_a1, alu_b1, rsp_data1);
        end
        total++;
        if ({req_ack4, rsp_valid4, busy4, alu_en4, alu_fun4, alu_a4, alu_b4, rsp_data4} !== '0) begin
            bad++;
            $display("FAIL reset_l4: got ack=%b rv=%b busy=%b en=%b fun=%h a=%h b=%h data=%h required all 0",
                     req_ack4, rsp_valid4, busy4, alu_en4, alu_fun4, alu_a4, alu_b4, rsp_data4);
        end
        @(negedge clk);
        @(negedge clk);
        async_rst = 1'b1;
    endtask

    // req0, fun 0, 3 + 4 -> 7 with latency 1.
    task automatic test_single();
        do_reset();
        req_fun1[3:0] = 4'd0; req_a1[15:0] = 16'h0003; req_b1[15:0] = 16'h0004;
        req1 = 2'b01;
        @(negedge clk); // C+1
        total++;
        if ({req_ack1, rsp_valid1, busy1, alu_en1} !== 6'b01_00_1_1) begin
            bad++; $display("FAIL single_issue: got ack=%b rv=%b busy=%b en=%b required 01 00 1 1",
                            req_ack1, rsp_valid1, busy1, alu_en1);
        end
        total++;
        if ({alu_fun1, alu_a1, alu_b1} !== {4'd0, 16'h0003, 16'h0004}) begin
            bad++; $display("FAIL single_operands: got fun=%h a=%h b=%h required 0 0003 0004",
                            alu_fun1, alu_a1, alu_b1);
        end
        req1 = 2'b00;
        @(negedge clk); // C+2
        total++;
        if ({req_ack1, rsp_valid1, busy1, alu_en1, alu_a1, alu_b1} !== {6'b00_00_1_0, 32'h0}) begin
            bad++; $display("FAIL single_wait: got ack=%b rv=%b busy=%b en=%b a=%h b=%h required 00 00 1 0 0 0",
                            req_ack1, rsp_valid1, busy1, alu_en1, alu_a1, alu_b1);
        end
        @(negedge clk); // C+3
        total++;
        if ({req_ack1, rsp_valid1, busy1, alu_en1, rsp_data1} !== {6'b00_01_0_0, 16'h0007}) begin
            bad++; $display("FAIL single_rsp: got ack=%b rv=%b busy=%b en=%b data=%h required 00 01 0 0 0007",
                            req_ack1, rsp_valid1, busy1, alu_en1, rsp_data1);
        end
    endtask

    // Both requesters held high: grants alternate 0,1,0,1.
    task automatic test_contention();
        logic [NR-1:0] oh;
        logic [DW-1:0] exp_d;
        do_reset();
        req_fun1 = {4'd1, 4'd0};
        req_a1   = {16'h0010, 16'h0003};
        req_b1   = {16'h0001, 16'h0004};
        req1     = 2'b11;
        for (int k = 0; k < 4; k++) begin
            oh    = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (k % 2 == 0) ? 16'h0007 : 16'h000F;
            @(negedge clk);
            total++;
            if ({req_ack1, rsp_valid1} !== {oh, 2'b00}) begin
                bad++; $display("FAIL contention_ack[%0d]: got ack=%b rv=%b required ack=%b rv=00",
                                k, req_ack1, rsp_valid1, oh);
            end
            @(negedge clk);
            @(negedge clk);
            total++;
            if ({req_ack1, rsp_valid1, rsp_data1} !== {2'b00, oh, exp_d}) begin
                bad++; $display("FAIL contention_rsp[%0d]: got ack=%b rv=%b data=%h required ack=00 rv=%b data=%h",
                                k, req_ack1, rsp_valid1, rsp_data1, oh, exp_d);
            end
        end
        req1 = 2'b00;
    endtask

    // Latency 4: wrap-around add on requester 1, then an ordinary add on requester 0.
    task automatic test_latency4();
        logic [NR-1:0] oh_t  [2];
        logic [DW-1:0] a_t   [2];
        logic [DW-1:0] b_t   [2];
        logic [DW-1:0] exp_t [2];
        oh_t[0] = 2'b10; a_t[0] = 16'hFFFF; b_t[0] = 16'h0001; exp_t[0] = 16'h0000;
        oh_t[1] = 2'b01; a_t[1] = 16'h1234; b_t[1] = 16'h1111; exp_t[1] = 16'h2345;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            req_fun4 = '0;
            req_a4   = {a_t[k], a_t[k]};
            req_b4   = {b_t[k], b_t[k]};
            req4     = oh_t[k];
            @(negedge clk); // C+1
            total++;
            if ({req_ack4, rsp_valid4, busy4, alu_en4, alu_a4, alu_b4} !== {oh_t[k], 2'b00, 2'b11, a_t[k], b_t[k]}) begin
                bad++; $display("FAIL lat4_issue[%0d]: got ack=%b rv=%b busy=%b en=%b a=%h b=%h required ack=%b rv=00 1 1 a=%h b=%h",
                                k, req_ack4, rsp_valid4, busy4, alu_en4, alu_a4, alu_b4, oh_t[k], a_t[k], b_t[k]);
            end
            req4 = 2'b00;
            for (int c = 2; c <= 5; c++) begin
                @(negedge clk);
                total++;
                if ({req_ack4, rsp_valid4, busy4, alu_en4} !== 6'b00_00_1_0) begin
                    bad++; $display("FAIL lat4_wait[%0d] C+%0d: got ack=%b rv=%b busy=%b en=%b required 00 00 1 0",
                                    k, c, req_ack4, rsp_valid4, busy4, alu_en4);
                end
            end
            @(negedge clk); // C+6
            total++;
            if ({req_ack4, rsp_valid4, busy4, alu_en4, rsp_data4} !== {2'b00, oh_t[k], 2'b00, exp_t[k]}) begin
                bad++; $display("FAIL lat4_rsp[%0d]: got ack=%b rv=%b busy=%b en=%b data=%h required 00 %b 0 0 %h",
                                k, req_ack4, rsp_valid4, busy4, alu_en4, rsp_data4, oh_t[k], exp_t[k]);
            end
        end
    endtask

    // req0 held with operands re-randomised every cycle; ALU lines must be zero
    // except in the issue cycle, which carries the values sampled just before.
    task automatic test_isolation();
        logic [FW-1:0] pf;
        logic [DW-1:0] pa, pb, e;
        do_reset();
        req_fun1[3:0]  = 4'($urandom_range(0, 1));
        req_a1         = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
        req_b1         = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
        pf = req_fun1[3:0]; pa = req_a1[15:0]; pb = req_b1[15:0];
        req1 = 2'b01;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i % 3 == 1) begin
                total++;
                if ({alu_en1, alu_fun1, alu_a1, alu_b1} !== {1'b1, pf, pa, pb}) begin
                    bad++; $display("FAIL iso_issue[%0d]: got en=%b fun=%h a=%h b=%h required 1 %h %h %h",
                                    i, alu_en1, alu_fun1, alu_a1, alu_b1, pf, pa, pb);
                end
                exp_q.push_back(alu_f(pf, pa, pb));
            end else begin
                total++;
                if ({alu_en1, alu_fun1, alu_a1, alu_b1} !== '0) begin
                    bad++; $display("FAIL iso_quiet[%0d]: got en=%b fun=%h a=%h b=%h required all 0",
                                    i, alu_en1, alu_fun1, alu_a1, alu_b1);
                end
                if (i % 3 == 0) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                    total++;
                    if ({rsp_valid1, rsp_data1} !== {2'b01, e}) begin
                        bad++; $display("FAIL iso_rsp[%0d]: got rv=%b data=%h required 01 %h",
                                        i, rsp_valid1, rsp_data1, e);
                    end
                end
            end
            req_fun1[3:0]  = 4'($urandom_range(0, 1));
            req_a1         = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
            req_b1         = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
            pf = req_fun1[3:0]; pa = req_a1[15:0]; pb = req_b1[15:0];
        end
        req1 = 2'b00;
        @(negedge clk);
    endtask

    // Reset while in WAIT discards the op and restores ptr=0.
    task automatic test_reset_mid_op();
        req_fun1 = {4'd0, 4'd1};
        req_a1   = {16'h0009, 16'h0005};
        req_b1   = {16'h0004, 16'h0002};
        req1     = 2'b01;
        @(negedge clk);
        total++;
        if (req_ack1 !== 2'b01) begin
            bad++; $display("FAIL rmid_ack: got ack=%b required 01", req_ack1);
        end
        req1 = 2'b00;
        @(negedge clk); // WAIT
        async_rst = 1'b0;
        #1;
        total++;
        if ({req_ack1, rsp_valid1, busy1, alu_en1, alu_fun1, alu_a1, alu_b1, rsp_data1} !== '0) begin
            bad++; $display("FAIL rmid_async: got ack=%b rv=%b busy=%b en=%b fun=%h a=%h b=%h data=%h required all 0",
                            req_ack1, rsp_valid1, busy1, alu_en1, alu_fun1, alu_a1, alu_b1, rsp_data1);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid1, busy1} !== 3'b000) begin
            bad++; $display("FAIL rmid_held: got rv=%b busy=%b required 00 0", rsp_valid1, busy1);
        end
        async_rst = 1'b1;
        req1 = 2'b11;
        @(negedge clk);
        total++;
        if (req_ack1 !== 2'b01) begin
            bad++; $display("FAIL rmid_ptr0: got ack=%b required 01", req_ack1);
        end
        req1 = 2'b10;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({rsp_valid1, rsp_data1} !== {2'b01, 16'h0003}) begin
            bad++; $display("FAIL rmid_rsp0: got rv=%b data=%h required 01 0003", rsp_valid1, rsp_data1);
        end
        @(negedge clk);
        total++;
        if (req_ack1 !== 2'b10) begin
            bad++; $display("FAIL rmid_ack1: got ack=%b required 10", req_ack1);
        end
        req1 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({rsp_valid1, rsp_data1} !== {2'b10, 16'h000D}) begin
            bad++; $display("FAIL rmid_rsp1: got rv=%b data=%h required 10 000d", rsp_valid1, rsp_data1);
        end
    endtask

    // req0 pulsed only while a req1 op is in WAIT: must leave no trace.
    task automatic test_late_drop();
        do_reset();
        req_fun1 = {4'd0, 4'd0};
        req_a1   = {16'h0007, 16'h0100};
        req_b1   = {16'h0001, 16'h0200};
        req1     = 2'b10;
        @(negedge clk);
        total++;
        if (req_ack1 !== 2'b10) begin
            bad++; $display("FAIL late_ack1: got ack=%b required 10", req_ack1);
        end
        req1 = 2'b00;
        @(negedge clk); // WAIT
        req1 = 2'b01;
        @(negedge clk);
        req1 = 2'b00;
        total++;
        if ({req_ack1, rsp_valid1, rsp_data1} !== {2'b00, 2'b10, 16'h0008}) begin
            bad++; $display("FAIL late_rsp1: got ack=%b rv=%b data=%h required 00 10 0008",
                            req_ack1, rsp_valid1, rsp_data1);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({req_ack1, rsp_valid1, busy1} !== 5'b00_00_0) begin
                bad++; $display("FAIL late_quiet[%0d]: got ack=%b rv=%b busy=%b required 00 00 0",
                                c, req_ack1, rsp_valid1, busy1);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        async_rst = 1'b0;
        req1 = '0; req_fun1 = '0; req_a1 = '0; req_b1 = '0;
        req4 = '0; req_fun4 = '0; req_a4 = '0; req_b4 = '0;

        test_reset();
        test_single();
        test_contention();
        test_latency4();
        test_isolation();
        test_reset_mid_op();
        test_late_drop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter and sequencer that shares the single ALU datapath (arithmetic/logic/compare/shift units, registered output) between N requesters, such as the system controller and the register-file command path. It accepts one operation at a time, latches its operands, drives the ALU enable/function/operand lines for exactly one cycle, waits the ALU's fixed latency, and returns the captured result to the originating requester with a one-cycle valid pulse. Between operations all ALU inputs are forced to zero to suppress datapath toggling.

## Interface
- DATA_WIDTH, 16, operand and result width
- FUN_WIDTH, 4, ALU function code width
- N_REQ, 2, number of requesters (2..8)
- ALU_LATENCY, 1, cycles from ALU enable to valid alu_out (1..4)

- clk  input  1  clock
- async_rst  input  1  reset, asynchronous, active-low
- req  input  N_REQ  request per requester, level
- req_fun  input  N_REQ*FUN_WIDTH  function code, requester i at [i*FUN_WIDTH +: FUN_WIDTH]
- req_a, req_b  input  N_REQ*DATA_WIDTH  operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ack  output  N_REQ  one-hot pulse: request accepted and operands latched
- rsp_valid  output  N_REQ  one-hot pulse: rsp_data belongs to requester i
- rsp_data  output  DATA_WIDTH  captured ALU result, held until the next capture
- busy  output  1  high in every state except IDLE
- alu_en  output  1  ALU enable
- alu_fun  output  FUN_WIDTH  ALU function
- alu_a, alu_b  output  DATA_WIDTH  ALU operands
- alu_out  input  DATA_WIDTH  ALU registered result

## Operation
- States: IDLE, ISSUE, WAIT. Registered grant index g, priority pointer ptr, latency counter cnt, latched op/a/b.
- IDLE: if any req bit is set, select the first set bit scanning ptr, ptr+1, … modulo N_REQ. Latch g and that requester's fun/a/b, register req_ack[g]=1, go to ISSUE. If no req bit is set, stay in IDLE.
- ISSUE: alu_en=1, alu_fun/a/b = latched values, cnt loaded with ALU_LATENCY, go to WAIT. ptr ← (g+1) mod N_REQ.
- WAIT: cnt decrements each cycle. When cnt==1, alu_out is sampled into rsp_data at the clock edge, rsp_valid[g] is registered high, and the next state is IDLE.
- Outside ISSUE, alu_en=0 and alu_fun/alu_a/alu_b=0 (operand isolation).
- Requester contract:
  - req_fun/a/b must be stable only in the cycle that req is sampled in IDLE.
  - The requester drops req after seeing req_ack. If req is still high in the IDLE cycle after rsp_valid, it is treated as a new request.
  - A req dropped before acceptance is ignored with no side effects.
- Simultaneous requests: exactly one is granted. Others wait and are served in round-robin order. No requester waits more than N_REQ-1 operations.
- Arithmetic: none internal. rsp_data equals alu_out bit-exact.
- Reset (asynchronous, any state): state=IDLE, ptr=0, g=0, cnt=0, latched op/a/b=0, rsp_data=0. req_ack, rsp_valid, busy, alu_en, alu_fun, alu_a and alu_b all 0. An in-flight operation is discarded with no rsp_valid.

## Timing
- Request sampled in IDLE cycle C.
- req_ack[g] and busy high in C+1 (ISSUE), with alu_en=1 in C+1.
- WAIT occupies C+2 … C+1+ALU_LATENCY. alu_out is sampled at the end of C+1+ALU_LATENCY.
- rsp_valid[g]=1 and the new rsp_data appear in C+2+ALU_LATENCY. This is also an IDLE cycle, so a new request can be sampled then.
- Throughput: one operation per ALU_LATENCY+2 cycles. Latency from req to rsp_valid: ALU_LATENCY+2 cycles.
- req_ack and rsp_valid are exactly one cycle wide and never high in the same cycle.
- alu_en is high exactly one cycle per operation.

## Test plan
Bench ALU model: registered, latency ALU_LATENCY; fun 0 gives A+B, fun 1 gives A−B.
- Single request, N_REQ=2, L=1: req0, fun 0, a=0x0003, b=0x0004 sampled at C → req_ack[0] in C+1, alu_en only in C+1, rsp_valid[0] with rsp_data=0x0007 in C+3.
- Contention: req0 and req1 held high continuously after reset → grants alternate 0,1,0,1. Every rsp_valid is one-hot and matches its requester's operands (req1: fun 1, 0x0010−0x0001 gives 0x000F).
- Latency sweep L=4: req1, fun 0, 0xFFFF+0x0001 → rsp_data=0x0000 (wrap) in C+6. busy high C+1..C+5.
- Operand isolation: check alu_en/alu_fun/alu_a/alu_b=0 in every non-ISSUE cycle while req_a/req_b toggle randomly.
- Reset mid-operation: assert async_rst in WAIT → all outputs 0 immediately, no rsp_valid. After release, req1 pending with req0 pending → req0 granted first (ptr=0).
- Late drop: req0 pulsed for one cycle while a req1 operation is in WAIT → no req_ack[0] and no rsp_valid[0] afterwards.
